// File: rtl/cond_exec_unit.sv
// Per-lane NZCV flag registers with condition evaluation; flags commit only on passing lanes.
// Results are registered one cycle after accept; stall holds every register, flush drops the slot.
module cond_exec_unit #(
    parameter int NUM_LANES = 4,
    parameter int COND_MODE = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [3:0]             cond_i,
    input  logic [1:0]             flag_we_i,
    input  logic [4*NUM_LANES-1:0] flags_i,
    output logic [NUM_LANES-1:0]   cond_ex_o,
    output logic                   valid_o,
    output logic [4*NUM_LANES-1:0] flags_o,
    output logic [CNT_W-1:0]       exec_cnt_o,
    output logic [CNT_W-1:0]       squash_cnt_o
);

    logic                   accept;
    logic [3:0]             cond;
    logic [NUM_LANES-1:0]   pass;
    logic [4*NUM_LANES-1:0] flags_nxt;

    // Odd codes invert the base test of their pair, except 1111 which is always true.
    function automatic logic lane_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = ~(n ^ v);
            3'd6:    base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
    endfunction

    assign accept = valid_i & ~stall_i & ~flush_i;

    // Legacy 3-bit codes are translated onto the equivalent full encoding.
    always_comb begin
        cond = cond_i;
        if (COND_MODE == 0) begin
            case (cond_i[2:0])
                3'b011:  cond = 4'b0000;
                3'b100:  cond = 4'b0001;
                3'b101:  cond = 4'b1100;
                3'b110:  cond = 4'b1011;
                default: cond = 4'b1110;
            endcase
        end
    end

    always_comb begin
        pass      = '0;
        flags_nxt = flags_o;
        for (int k = 0; k < NUM_LANES; k++) begin
            pass[k] = lane_pass(cond, flags_o[4*k +: 4]);
            if (pass[k]) begin
                if (flag_we_i[1]) flags_nxt[4*k+2 +: 2] = flags_i[4*k+2 +: 2];
                if (flag_we_i[0]) flags_nxt[4*k   +: 2] = flags_i[4*k   +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_ex_o    <= '0;
            valid_o      <= 1'b0;
            flags_o      <= '0;
            exec_cnt_o   <= '0;
            squash_cnt_o <= '0;
        end else if (flush_i) begin
            cond_ex_o <= '0;
            valid_o   <= 1'b0;
        end else if (stall_i) begin
            valid_o <= valid_o;
        end else if (accept) begin
            cond_ex_o <= pass;
            valid_o   <= 1'b1;
            flags_o   <= flags_nxt;
            if (pass[0]) begin
                if (exec_cnt_o != {CNT_W{1'b1}}) exec_cnt_o <= exec_cnt_o + CNT_W'(1);
            end else begin
                if (squash_cnt_o != {CNT_W{1'b1}}) squash_cnt_o <= squash_cnt_o + CNT_W'(1);
            end
        end else begin
            cond_ex_o <= '0;
            valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Two instances (4-bit encoding / 16-bit counters, legacy encoding / 2-bit counters) share stimulus
// and are checked every cycle against a behavioural flag/counter model.
module tb_cond_exec_unit;

    localparam int NL = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_i, stall_i, flush_i;
    logic [3:0]     cond_i;
    logic [1:0]     flag_we_i;
    logic [4*NL-1:0] flags_i;

    logic [NL-1:0]   cex0, cex1;
    logic            vld0, vld1;
    logic [4*NL-1:0] flg0, flg1;
    logic [15:0]     ex0, sq0;
    logic [1:0]      ex1, sq1;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = full encoding instance, 1 = legacy instance.
    bit [3:0]    m_flags [2][NL];
    bit          m_valid [2];
    bit [NL-1:0] m_cex   [2];
    int          m_exec  [2];
    int          m_squash[2];
    int          m_max   [2] = '{65535, 3};

    always #5 clk = ~clk;

    cond_exec_unit #(.NUM_LANES(NL), .COND_MODE(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .cond_i(cond_i), .flag_we_i(flag_we_i), .flags_i(flags_i),
        .cond_ex_o(cex0), .valid_o(vld0), .flags_o(flg0),
        .exec_cnt_o(ex0), .squash_cnt_o(sq0));

    cond_exec_unit #(.NUM_LANES(NL), .COND_MODE(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .cond_i(cond_i), .flag_we_i(flag_we_i), .flags_i(flags_i),
        .cond_ex_o(cex1), .valid_o(vld1), .flags_o(flg1),
        .exec_cnt_o(ex1), .squash_cnt_o(sq1));

    function automatic bit ref_pass(int mode, bit [3:0] c, bit [3:0] f);
        bit n  = f[3];
        bit z  = f[2];
        bit cf = f[1];
        bit v  = f[0];
        bit ge = (n == v);
        if (mode == 0) begin
            case (c[2:0])
                3'd3:    return z;
                3'd4:    return !z;
                3'd5:    return !z && ge;
                3'd6:    return !ge;
                default: return 1'b1;
            endcase
        end
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cf;
            4'd3:    return !cf;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cf && !z;
            4'd9:    return !cf || z;
            4'd10:   return ge;
            4'd11:   return !ge;
            4'd12:   return !z && ge;
            4'd13:   return z || !ge;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit [4*NL-1:0] model_flags(int d);
        bit [4*NL-1:0] r = '0;
        for (int k = 0; k < NL; k++) r[4*k +: 4] = m_flags[d][k];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0; m_cex[d] = '0; m_exec[d] = 0; m_squash[d] = 0;
                for (int k = 0; k < NL; k++) m_flags[d][k] = 4'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (flush_i) begin
                    m_valid[d] = 0; m_cex[d] = '0;
                end else if (stall_i) begin
                    m_valid[d] = m_valid[d];
                end else if (valid_i) begin
                    bit [NL-1:0] p;
                    for (int k = 0; k < NL; k++) p[k] = ref_pass(d == 0 ? 1 : 0, cond_i, m_flags[d][k]);
                    for (int k = 0; k < NL; k++) begin
                        if (p[k] && flag_we_i[1]) m_flags[d][k][3:2] = flags_i[4*k+2 +: 2];
                        if (p[k] && flag_we_i[0]) m_flags[d][k][1:0] = flags_i[4*k +: 2];
                    end
                    if (p[0]) m_exec[d]   = (m_exec[d]   < m_max[d]) ? m_exec[d] + 1   : m_max[d];
                    else      m_squash[d] = (m_squash[d] < m_max[d]) ? m_squash[d] + 1 : m_max[d];
                    m_valid[d] = 1; m_cex[d] = p;
                end else begin
                    m_valid[d] = 0; m_cex[d] = '0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("d0_valid",  32'(vld0), 32'(m_valid[0]));
        chk("d0_cex",    32'(cex0), 32'(m_cex[0]));
        chk("d0_flags",  32'(flg0), 32'(model_flags(0)));
        chk("d0_exec",   32'(ex0),  m_exec[0]);
        chk("d0_squash", 32'(sq0),  m_squash[0]);
        chk("d1_valid",  32'(vld1), 32'(m_valid[1]));
        chk("d1_cex",    32'(cex1), 32'(m_cex[1]));
        chk("d1_flags",  32'(flg1), 32'(model_flags(1)));
        chk("d1_exec",   32'(ex1),  m_exec[1]);
        chk("d1_squash", 32'(sq1),  m_squash[1]);
    end

    task automatic tick(input bit v, input bit s, input bit f, input bit [3:0] c,
                        input bit [1:0] we, input bit [15:0] fl);
        valid_i = v; stall_i = s; flush_i = f; cond_i = c; flag_we_i = we; flags_i = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 0; stall_i = 0; flush_i = 0; cond_i = 0; flag_we_i = 0; flags_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("lit_rst_valid", 32'(vld0), 0);
        chk("lit_rst_flags", 32'(flg0), 0);
        chk("lit_rst_cnt",   32'({ex0, sq0}), 0);

        tick(1, 0, 0, 4'b0000, 2'b00, 16'h0000);
        chk("lit_eq_first_cex", 32'(cex0), 32'h0);
        chk("lit_eq_first_vld", 32'(vld0), 1);
        chk("lit_eq_first_sq",  32'(sq0), 1);
        chk("lit_eq_first_ex",  32'(ex0), 0);

        tick(1, 0, 0, 4'b1110, 2'b11, 16'h1804);
        tick(1, 0, 0, 4'b0000, 2'b00, 16'h0000);
        chk("lit_b2b_eq_cex", 32'(cex0), 32'h1);
        chk("lit_b2b_flags",  32'(flg0), 32'h1804);
        chk("lit_b2b_lane2",  32'(flg0[11:8]), 32'h8);

        tick(1, 0, 0, 4'b1110, 2'b11, 16'h0340);
        tick(1, 0, 0, 4'b0001, 2'b10, 16'hFFFF);
        chk("lit_pred_cex",   32'(cex0), 32'hD);
        chk("lit_pred_flags", 32'(flg0), 32'hCF4C);

        tick(1, 0, 0, 4'b1110, 2'b11, 16'h9018);
        tick(1, 0, 0, 4'b1011, 2'b00, 16'h0000);
        chk("lit_lt", 32'(cex0), 32'h3);
        tick(1, 0, 0, 4'b1010, 2'b00, 16'h0000);
        chk("lit_ge", 32'(cex0), 32'hC);
        tick(1, 0, 0, 4'b1100, 2'b00, 16'h0000);
        chk("lit_gt", 32'(cex0), 32'hC);
        tick(1, 0, 0, 4'b1101, 2'b00, 16'h0000);
        chk("lit_le", 32'(cex0), 32'h3);

        tick(1, 0, 0, 4'b0111, 2'b11, 16'h0040);
        chk("lit_vc_cex",   32'(cex0), 32'h5);
        chk("lit_leg_al",   32'(cex1), 32'hF);
        tick(1, 0, 0, 4'b1011, 2'b00, 16'h0000);
        chk("lit_leg_eq",   32'(cex1), 32'h2);
        tick(1, 0, 0, 4'b0001, 2'b00, 16'h0000);
        chk("lit_leg_other", 32'(cex1), 32'hF);
        chk("lit_leg_sat",   32'(ex1), 3);

        tick(1, 0, 0, 4'b1110, 2'b00, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 4'b0000, 2'b11, 16'hFFFF);
            chk("lit_stall_vld", 32'(vld0), 1);
            chk("lit_stall_cex", 32'(cex0), 32'hF);
        end
        tick(1, 0, 1, 4'b1110, 2'b11, 16'hFFFF);
        chk("lit_flush_vld",   32'(vld0), 0);
        chk("lit_flush_flags", 32'(flg0), 32'h9010);
        tick(1, 0, 0, 4'b1110, 2'b00, 16'h0000);
        tick(1, 1, 1, 4'b1110, 2'b11, 16'hFFFF);
        chk("lit_flush_stall_vld", 32'(vld0), 0);

        tick(1, 0, 0, 4'b1110, 2'b11, 16'h5555);
        tick(1, 1, 0, 4'b1110, 2'b11, 16'hAAAA);
        rst = 1'b1;
        #1;
        chk("lit_rst_mid_d0", 32'({vld0, cex0, flg0, ex0, sq0}) , 0);
        chk("lit_rst_mid_d1", 32'({vld1, cex1, flg1, ex1, sq1}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom()));
        end
        rst = 1'b0;
        tick(0, 0, 0, 4'b0000, 2'b00, 16'h0000);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
